// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between NUM_REQ requesters, with lock bursts.
// Grant is combinational (0-cycle); read data returns tagged one cycle later; freeze stalls all grants.
module mem_port_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  input  logic                      freeze,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      busy
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic               owner_vld_q, owner_vld_d;
  logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [NUM_REQ-1:0] rvalid_q, rvalid_d;

  logic               gnt_any;
  logic [PTR_W-1:0]   gnt_idx;
  logic [PTR_W:0]     cand;

  // Grant select; reset is folded in so the RAM sees no access while reset is held.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (reset && !freeze) begin
      if (owner_vld_q && req[owner_q] && lock[owner_q] &&
          (burst_cnt_q < CNT_W'(MAX_BURST))) begin
        gnt_any = 1'b1;
        gnt_idx = owner_q;
      end else begin
        for (int i = 0; i < NUM_REQ; i++) begin
          cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
          if (cand >= (PTR_W+1)'(NUM_REQ)) begin
            cand = cand - (PTR_W+1)'(NUM_REQ);
          end
          if (!gnt_any && req[cand[PTR_W-1:0]]) begin
            gnt_any = 1'b1;
            gnt_idx = cand[PTR_W-1:0];
          end
        end
      end
    end
  end

  always_comb begin
    gnt       = '0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_any) begin
      gnt       = NUM_REQ'(1) << gnt_idx;
      mem_we    = we[gnt_idx];
      mem_addr  = addr[gnt_idx*ADDR_W +: ADDR_W];
      mem_wdata = wdata[gnt_idx*DATA_W +: DATA_W];
    end
  end

  assign busy   = gnt_any;
  assign rvalid = rvalid_q;
  assign rdata  = mem_rdata;

  // Pointer always moves past the granted requester, so a forced rotation
  // naturally resumes from owner+1.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    owner_vld_d = owner_vld_q;
    burst_cnt_d = burst_cnt_q;
    rvalid_d    = '0;
    if (gnt_any) begin
      rr_ptr_d = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
      if (owner_vld_q && (owner_q == gnt_idx)) begin
        burst_cnt_d = (burst_cnt_q == CNT_W'(MAX_BURST)) ? burst_cnt_q
                                                          : burst_cnt_q + CNT_W'(1);
      end else begin
        burst_cnt_d = CNT_W'(1);
      end
      owner_vld_d = lock[gnt_idx];
      owner_d     = gnt_idx;
      if (!we[gnt_idx]) begin
        rvalid_d = gnt;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      owner_vld_q <= 1'b0;
      burst_cnt_q <= '0;
      rvalid_q    <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      owner_vld_q <= owner_vld_d;
      burst_cnt_q <= burst_cnt_d;
      rvalid_q    <= rvalid_d;
    end
  end

endmodule
